// File: rtl/rocketcpu_wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter: one transaction per grant, an idle cycle between grants.
// Optional slave-ack watchdog enabled by defining ROCKETCPU_ARB_TIMEOUT_EN.
module rocketcpu_wb_master_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] TO_RDATA = 32'h0000_0000
) (
    input  logic        i_wb_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    input  logic [3:0]  i_m0_sel,
    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t state_q, state_d;
    logic   last_q, last_d;  // 1'b1: master 1 held the most recent grant
    logic   gnt_cyc_s;
    logic   ack_s;
    logic   to_s;

    // Request line of whichever master currently owns the bus.
    always_comb begin
        case (state_q)
            GNT0:    gnt_cyc_s = i_m0_cyc;
            GNT1:    gnt_cyc_s = i_m1_cyc;
            default: gnt_cyc_s = 1'b0;
        endcase
        ack_s = i_wb_ack & gnt_cyc_s;
    end

`ifdef ROCKETCPU_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Watchdog fires only while the owner still holds cyc; a real ack wins.
    always_comb begin
        to_s  = gnt_cyc_s & ~i_wb_ack & (cnt_q == TO_LAST);
        if (state_q == IDLE) begin
            cnt_d = 16'd0;
        end else if (!ack_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_to_s;
    assign unused_to_s = ^TO_LAST;
    assign to_s        = 1'b0;
`endif

    // Arbitration and grant-release decisions.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (i_m0_cyc) begin
                    state_d = GNT0;
                end else if (i_m1_cyc) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (!i_m0_cyc || ack_s || to_s) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else begin
                    state_d = GNT0;
                end
            end
            GNT1: begin
                if (!i_m1_cyc || ack_s || to_s) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else begin
                    state_d = GNT1;
                end
            end
            default: begin
                state_d = IDLE;
                last_d  = 1'b1;
            end
        endcase
    end

    // FSM state and round-robin history.
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Slave-side request mux and master-side response routing.
    always_comb begin
        o_wb_adr = 32'h0000_0000;
        o_wb_dat = 32'h0000_0000;
        o_wb_sel = 4'h0;
        o_wb_we  = 1'b0;
        o_m0_rdt = 32'h0000_0000;
        o_m1_rdt = 32'h0000_0000;
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;
        case (state_q)
            GNT0: begin
                o_wb_adr = i_m0_adr;
                o_wb_dat = i_m0_dat;
                o_wb_sel = i_m0_sel;
                o_wb_we  = i_m0_we;
                o_m0_rdt = to_s ? TO_RDATA : i_wb_rdt;
                o_m0_ack = ack_s | to_s;
            end
            GNT1: begin
                o_wb_adr = i_m1_adr;
                o_wb_dat = i_m1_dat;
                o_wb_sel = i_m1_sel;
                o_wb_we  = i_m1_we;
                o_m1_rdt = to_s ? TO_RDATA : i_wb_rdt;
                o_m1_ack = ack_s | to_s;
            end
            default: begin
                o_wb_adr = 32'h0000_0000;
            end
        endcase
        o_wb_cyc  = gnt_cyc_s & ~to_s;
        o_grant   = {state_q == GNT1, state_q == GNT0};
        o_timeout = to_s;
    end

endmodule

// File: tb/tb_rocketcpu_wb_master_arbiter.sv
// Directed-vector bench for the two-master Wishbone arbiter.
module tb_rocketcpu_wb_master_arbiter;

    localparam logic [31:0] M0_ADR = 32'h0000_0010;
    localparam logic [31:0] M0_DAT = 32'h1111_1111;
    localparam logic [3:0]  M0_SEL = 4'h3;
    localparam logic [31:0] M1_ADR = 32'h1000_0004;
    localparam logic [31:0] M1_DAT = 32'hCAFE_0001;
    localparam logic [3:0]  M1_SEL = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m0_adr = 32'h0, m0_dat = 32'h0, m1_adr = 32'h0, m1_dat = 32'h0;
    logic [3:0]  m0_sel = 4'h0, m1_sel = 4'h0;
    logic        m0_we = 1'b0, m1_we = 1'b0, m0_cyc = 1'b0, m1_cyc = 1'b0;
    logic [31:0] m0_rdt, m1_rdt, wb_adr, wb_dat;
    logic        m0_ack, m1_ack, wb_we, wb_cyc, timeout;
    logic [3:0]  wb_sel;
    logic [31:0] wb_rdt = 32'h0;
    logic        wb_ack = 1'b0;
    logic [1:0]  grant;

    int n_cmp  = 0;
    int n_fail = 0;

    rocketcpu_wb_master_arbiter #(.TIMEOUT(8), .TO_RDATA(32'h0000_0000)) dut (
        .i_wb_clk(clk), .i_rst_n(rst_n),
        .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
        .i_m0_cyc(m0_cyc), .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
        .i_m1_cyc(m1_cyc), .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
        .o_wb_cyc(wb_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
        .o_grant(grant), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        c0;
        logic        c1;
        logic        ack;
        logic [31:0] rdt;
        logic [1:0]  g;
        logic        cyc;
        logic        a0;
        logic        a1;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [31:0] e_adr, e_dat, e_r0, e_r1;
        logic [3:0]  e_sel;
        logic        e_we;
        bit          seen;

        //          rst   c0    c1    ack   rdt            g      cyc   a0    a1
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h55AA55AA, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0};

        m0_adr = M0_ADR; m0_dat = M0_DAT; m0_sel = M0_SEL; m0_we = 1'b0;
        m1_adr = M1_ADR; m1_dat = M1_DAT; m1_sel = M1_SEL; m1_we = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_grant", -1, 32'(grant), 32'h0);
        chk("reset_cyc", -1, 32'(wb_cyc), 32'h0);
        chk("reset_adr", -1, wb_adr, 32'h0);
        chk("reset_rdt0", -1, m0_rdt, 32'h0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst_n  = ~vecs[i].rst;
            m0_cyc = vecs[i].c0;
            m1_cyc = vecs[i].c1;
            wb_ack = vecs[i].ack;
            wb_rdt = vecs[i].rdt;
            #1;
            e_adr = 32'h0; e_dat = 32'h0; e_sel = 4'h0; e_we = 1'b0;
            e_r0 = 32'h0; e_r1 = 32'h0;
            if (vecs[i].g == 2'b01) begin
                e_adr = M0_ADR; e_dat = M0_DAT; e_sel = M0_SEL; e_we = 1'b0; e_r0 = vecs[i].rdt;
            end else if (vecs[i].g == 2'b10) begin
                e_adr = M1_ADR; e_dat = M1_DAT; e_sel = M1_SEL; e_we = 1'b1; e_r1 = vecs[i].rdt;
            end
            chk("grant", i, 32'(grant), 32'(vecs[i].g));
            chk("wb_cyc", i, 32'(wb_cyc), 32'(vecs[i].cyc));
            chk("m0_ack", i, 32'(m0_ack), 32'(vecs[i].a0));
            chk("m1_ack", i, 32'(m1_ack), 32'(vecs[i].a1));
            chk("m0_rdt", i, m0_rdt, e_r0);
            chk("m1_rdt", i, m1_rdt, e_r1);
            chk("wb_adr", i, wb_adr, e_adr);
            chk("wb_dat", i, wb_dat, e_dat);
            chk("wb_sel", i, 32'(wb_sel), 32'(e_sel));
            chk("wb_we", i, 32'(wb_we), 32'(e_we));
            chk("timeout", i, 32'(timeout), 32'h0);
        end

        // Asynchronous reset in the middle of a master 0 grant.
        @(negedge clk);
        m0_cyc = 1'b1; wb_ack = 1'b0; wb_rdt = 32'h0;
        @(negedge clk);
        #1;
        chk("pre_rst_grant", 100, 32'(grant), 32'h1);
        wb_ack = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 101, 32'(wb_cyc), 32'h0);
        chk("mid_rst_grant", 102, 32'(grant), 32'h0);
        chk("mid_rst_ack", 103, 32'(m0_ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; wb_ack = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (!seen && grant == 2'b01) seen = 1'b1;
        end
        chk("regrant_after_rst", 104, 32'(seen), 32'h1);
        m0_cyc = 1'b0;

`ifdef ROCKETCPU_ARB_TIMEOUT_EN
        // Master 1 targets a slave that never acks; watchdog expires on the 8th grant cycle.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; m1_cyc = 1'b1; wb_ack = 1'b0; wb_rdt = 32'hFFFF_FFFF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) m0_cyc = 1'b1;
            #1;
            chk("to_grant", 200 + k, 32'(grant), 32'h2);
            chk("to_m1_ack", 200 + k, 32'(m1_ack), (k == 8) ? 32'h1 : 32'h0);
            chk("to_pulse", 200 + k, 32'(timeout), (k == 8) ? 32'h1 : 32'h0);
            chk("to_cyc", 200 + k, 32'(wb_cyc), (k == 8) ? 32'h0 : 32'h1);
            chk("to_m1_rdt", 200 + k, m1_rdt, (k == 8) ? 32'h0 : 32'hFFFF_FFFF);
        end
        @(negedge clk);
        #1;
        chk("to_idle_grant", 210, 32'(grant), 32'h0);
        chk("to_idle_pulse", 210, 32'(timeout), 32'h0);
        @(negedge clk);
        #1;
        chk("to_next_m0", 211, 32'(grant), 32'h1);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
